// File: rtl/tap_state_machine.sv
// IEEE 1149.1 TAP controller: 16-state Moore FSM on TCK/TMS with registered
// state decodes for the IR/DR capture, shift and update paths.
module tap_state_machine (
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output logic [3:0] tap_state,
    output logic       tap_reset,
    output logic       run_idle,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir,
    output logic       pause,
    output logic       ir_select,
    output logic       tdo_en
);

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_e;

    typedef struct packed {
        logic tap_reset;
        logic run_idle;
        logic capture_dr;
        logic shift_dr;
        logic update_dr;
        logic capture_ir;
        logic shift_ir;
        logic update_ir;
        logic pause;
        logic ir_select;
        logic tdo_en;
    } tap_out_t;

    localparam tap_out_t RST_OUTS = 11'b100_0000_0000;

    tap_state_e state_q;
    tap_out_t   out_q;

    function automatic tap_state_e next_state(input tap_state_e s, input logic tms);
        case (s)
            TEST_LOGIC_RESET: return tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    return tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_DR:        return tms ? SELECT_IR        : CAPTURE_DR;
            CAPTURE_DR:       return tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         return tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         return tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         return tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         return tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        return tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_IR:        return tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       return tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         return tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         return tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         return tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         return tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        return tms ? SELECT_DR        : RUN_TEST_IDLE;
            default:          return TEST_LOGIC_RESET;
        endcase
    endfunction

    function automatic tap_out_t decode(input tap_state_e s);
        tap_out_t o;
        o            = '0;
        o.tap_reset  = (s == TEST_LOGIC_RESET);
        o.run_idle   = (s == RUN_TEST_IDLE);
        o.capture_dr = (s == CAPTURE_DR);
        o.shift_dr   = (s == SHIFT_DR);
        o.update_dr  = (s == UPDATE_DR);
        o.capture_ir = (s == CAPTURE_IR);
        o.shift_ir   = (s == SHIFT_IR);
        o.update_ir  = (s == UPDATE_IR);
        o.pause      = (s == PAUSE_DR) || (s == PAUSE_IR);
        o.ir_select  = (s == SELECT_IR) || (s == CAPTURE_IR) || (s == SHIFT_IR) ||
                       (s == EXIT1_IR)  || (s == PAUSE_IR)   || (s == EXIT2_IR) ||
                       (s == UPDATE_IR);
        o.tdo_en     = (s == SHIFT_DR) || (s == SHIFT_IR);
        return o;
    endfunction

    // Outputs are decoded from the next state so they register alongside it,
    // keeping TMS out of every output path.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state_q <= TEST_LOGIC_RESET;
            out_q   <= RST_OUTS;
        end else begin
            state_q <= next_state(state_q, TMS);
            out_q   <= decode(next_state(state_q, TMS));
        end
    end

    assign tap_state  = state_q;
    assign tap_reset  = out_q.tap_reset;
    assign run_idle   = out_q.run_idle;
    assign capture_dr = out_q.capture_dr;
    assign shift_dr   = out_q.shift_dr;
    assign update_dr  = out_q.update_dr;
    assign capture_ir = out_q.capture_ir;
    assign shift_ir   = out_q.shift_ir;
    assign update_ir  = out_q.update_ir;
    assign pause      = out_q.pause;
    assign ir_select  = out_q.ir_select;
    assign tdo_en     = out_q.tdo_en;

endmodule

// File: tb/tb_tap_state_machine.sv
// Self-checking bench for tap_state_machine: directed scans, TLR reachability,
// async reset and a randomised walk against a reference transition model.
module tb_tap_state_machine;

    logic       TCK, TRST, TMS;
    logic [3:0] tap_state;
    logic       tap_reset, run_idle, capture_dr, shift_dr, update_dr;
    logic       capture_ir, shift_ir, update_ir, pause, ir_select, tdo_en;
    logic [10:0] outs;

    int checks = 0;
    int errors = 0;
    int upd_dr_pulses = 0;
    logic [3:0] m_state;
    logic [3:0] sb[$];

    tap_state_machine dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .tap_state(tap_state),
        .tap_reset(tap_reset), .run_idle(run_idle),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
        .pause(pause), .ir_select(ir_select), .tdo_en(tdo_en)
    );

    assign outs = {tap_reset, run_idle, capture_dr, shift_dr, update_dr,
                   capture_ir, shift_ir, update_ir, pause, ir_select, tdo_en};

    always @(posedge update_dr) upd_dr_pulses++;

    function automatic logic [3:0] tb_next(input logic [3:0] s, input logic t);
        case (s)
            4'hF: return t ? 4'hF : 4'hC;
            4'hC: return t ? 4'h7 : 4'hC;
            4'h7: return t ? 4'h4 : 4'h6;
            4'h6: return t ? 4'h1 : 4'h2;
            4'h2: return t ? 4'h1 : 4'h2;
            4'h1: return t ? 4'h5 : 4'h3;
            4'h3: return t ? 4'h0 : 4'h3;
            4'h0: return t ? 4'h5 : 4'h2;
            4'h5: return t ? 4'h7 : 4'hC;
            4'h4: return t ? 4'hF : 4'hE;
            4'hE: return t ? 4'h9 : 4'hA;
            4'hA: return t ? 4'h9 : 4'hA;
            4'h9: return t ? 4'hD : 4'hB;
            4'hB: return t ? 4'h8 : 4'hB;
            4'h8: return t ? 4'hD : 4'hA;
            default: return t ? 4'h7 : 4'hC;
        endcase
    endfunction

    function automatic logic [10:0] exp_outs(input logic [3:0] s);
        return {s == 4'hF, s == 4'hC, s == 4'h6, s == 4'h2, s == 4'h5,
                s == 4'hE, s == 4'hA, s == 4'hD, (s == 4'h3) || (s == 4'hB),
                s inside {4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD},
                (s == 4'h2) || (s == 4'hA)};
    endfunction

    // One TCK period; returns 2 time units after the rising edge.
    task automatic step(input logic t);
        TCK = 1'b0;
        TMS = t;
        m_state = tb_next(m_state, t);
        #5 TCK = 1'b1;
        #2;
    endtask

    task automatic do_reset();
        TCK = 1'b0;
        TRST = 1'b1;
        #2 TRST = 1'b0;
        m_state = 4'hF;
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        TCK = 1'b0; TMS = 1'b0; TRST = 1'b0;
        #3 TRST = 1'b1;
        #1;
        checks++;
        if (tap_state !== 4'hF || tap_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got state=%h tap_reset=%b want F/1", tap_state, tap_reset);
        end
        checks++;
        if (outs !== exp_outs(4'hF)) begin
            errors++;
            $display("FAIL reset_outs: got %b want %b", outs, exp_outs(4'hF));
        end
        #2 TRST = 1'b0;
        m_state = 4'hF;
        sb.push_back(4'hC);
        step(1'b0);
        exp = sb.pop_front();
        checks++;
        if (tap_state !== exp || run_idle !== 1'b1 || tap_reset !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got state=%h ri=%b tr=%b want %h/1/0",
                     tap_state, run_idle, tap_reset, exp);
        end
    endtask

    task automatic test_ir_scan();
        logic [8:0] tms_seq = 9'b110000110;
        logic [3:0] states[9] = '{4'h7, 4'h4, 4'hE, 4'hA, 4'hA, 4'hA, 4'h9, 4'hD, 4'hC};
        logic [3:0] exp;
        int n_shift = 0, n_upd = 0;
        for (int i = 0; i < 9; i++) begin
            sb.push_back(states[i]);
            step(tms_seq[8-i]);
            exp = sb.pop_front();
            n_shift += int'(shift_ir);
            n_upd += int'(update_ir);
            checks++;
            if (tap_state !== exp) begin
                errors++;
                $display("FAIL ir_scan_state[%0d]: got %h want %h", i, tap_state, exp);
            end
            checks++;
            if (outs !== exp_outs(exp)) begin
                errors++;
                $display("FAIL ir_scan_outs[%0d]: got %b want %b", i, outs, exp_outs(exp));
            end
        end
        checks++;
        if (n_shift != 3 || n_upd != 1) begin
            errors++;
            $display("FAIL ir_scan_counts: shift_ir=%0d update_ir=%0d want 3/1", n_shift, n_upd);
        end
    endtask

    task automatic test_dr_scan();
        logic [9:0] tms_seq = 10'b1001010110;
        logic [3:0] states[10] = '{4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0, 4'h2, 4'h1, 4'h5, 4'hC};
        logic [3:0] exp;
        int n_upd = 0;
        for (int i = 0; i < 10; i++) begin
            sb.push_back(states[i]);
            step(tms_seq[9-i]);
            exp = sb.pop_front();
            n_upd += int'(update_dr);
            checks++;
            if (tap_state !== exp) begin
                errors++;
                $display("FAIL dr_scan_state[%0d]: got %h want %h", i, tap_state, exp);
            end
            checks++;
            if (outs !== exp_outs(exp)) begin
                errors++;
                $display("FAIL dr_scan_outs[%0d]: got %b want %b", i, outs, exp_outs(exp));
            end
        end
        checks++;
        if (n_upd != 1) begin
            errors++;
            $display("FAIL dr_scan_update_count: got %0d want 1", n_upd);
        end
    endtask

    task automatic test_all_to_tlr();
        logic [7:0] pbits[16];
        int plen[16];
        logic [3:0] exp;
        pbits[4'hF] = 8'b0;       plen[4'hF] = 0;
        pbits[4'hC] = 8'b0;       plen[4'hC] = 1;
        pbits[4'h7] = 8'b01;      plen[4'h7] = 2;
        pbits[4'h6] = 8'b010;     plen[4'h6] = 3;
        pbits[4'h2] = 8'b0100;    plen[4'h2] = 4;
        pbits[4'h1] = 8'b0101;    plen[4'h1] = 4;
        pbits[4'h3] = 8'b01010;   plen[4'h3] = 5;
        pbits[4'h0] = 8'b010101;  plen[4'h0] = 6;
        pbits[4'h5] = 8'b01011;   plen[4'h5] = 5;
        pbits[4'h4] = 8'b011;     plen[4'h4] = 3;
        pbits[4'hE] = 8'b0110;    plen[4'hE] = 4;
        pbits[4'hA] = 8'b01100;   plen[4'hA] = 5;
        pbits[4'h9] = 8'b01101;   plen[4'h9] = 5;
        pbits[4'hB] = 8'b011010;  plen[4'hB] = 6;
        pbits[4'h8] = 8'b0110101; plen[4'h8] = 7;
        pbits[4'hD] = 8'b011011;  plen[4'hD] = 6;
        for (int s = 0; s < 16; s++) begin
            do_reset();
            for (int i = plen[s] - 1; i >= 0; i--) step(pbits[s][i]);
            checks++;
            if (tap_state !== 4'(s)) begin
                errors++;
                $display("FAIL walk_to_%h: got %h want %h", s, tap_state, 4'(s));
            end
            for (int k = 0; k < 5; k++) step(1'b1);
            sb.push_back(4'hF);
            exp = sb.pop_front();
            checks++;
            if (tap_state !== exp || tap_reset !== 1'b1) begin
                errors++;
                $display("FAIL five_ones_from_%h: got %h/%b want %h/1", s, tap_state, tap_reset, exp);
            end
        end
        do_reset();
        step(1'b1);
        checks++;
        if (tap_state !== 4'hF) begin
            errors++;
            $display("FAIL tlr_hold: got %h want F", tap_state);
        end
    endtask

    task automatic test_async_reset();
        int pulses0;
        do_reset();
        pulses0 = upd_dr_pulses;
        step(1'b0); step(1'b1); step(1'b0); step(1'b0);
        checks++;
        if (tap_state !== 4'h2 || tdo_en !== 1'b1) begin
            errors++;
            $display("FAIL shift_dr_entry: got %h/%b want 2/1", tap_state, tdo_en);
        end
        #1 TCK = 1'b0;
        #1 TRST = 1'b1;
        #1;
        checks++;
        if (tdo_en !== 1'b0 || tap_state !== 4'hF) begin
            errors++;
            $display("FAIL async_reset: got tdo_en=%b state=%h want 0/F", tdo_en, tap_state);
        end
        #1 TRST = 1'b0;
        m_state = 4'hF;
        step(1'b0);
        checks++;
        if (tap_state !== 4'hC || upd_dr_pulses != pulses0) begin
            errors++;
            $display("FAIL async_no_update: got state=%h pulses=%0d want C/%0d",
                     tap_state, upd_dr_pulses, pulses0);
        end
    endtask

    task automatic test_random();
        logic [3:0] exp;
        for (int i = 0; i < 10000; i++) begin
            logic t;
            t = 1'($urandom_range(0, 1));
            sb.push_back(tb_next(m_state, t));
            step(t);
            exp = sb.pop_front();
            checks++;
            if (tap_state !== exp || outs !== exp_outs(exp)) begin
                errors++;
                $display("FAIL random[%0d]: got %h/%b want %h/%b", i, tap_state, outs, exp, exp_outs(exp));
                m_state = tap_state;
            end
            checks++;
            if ($countones({capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir}) > 1) begin
                errors++;
                $display("FAIL strobe_exclusive[%0d]: got %b want at most one", i,
                         {capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir});
            end
        end
    endtask

    initial begin
        TCK = 1'b0; TRST = 1'b0; TMS = 1'b0;
        m_state = 4'hF;
        test_reset();
        test_ir_scan();
        test_dr_scan();
        test_all_to_tlr();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
